// File: rtl/fifo_demux2_pkg.sv
// Shared types and constants for the fifo_demux2 stream demultiplexer.
// Define FIFO_DEMUX2_PASSTHRU_EN to let a full output stage reload in the cycle it drains.
package fifo_demux2_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;

  // Routing encodings carried on the select stream
  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

`ifdef FIFO_DEMUX2_PASSTHRU_EN
  localparam bit PassthruEn = 1'b1;
`else
  localparam bit PassthruEn = 1'b0;
`endif

  typedef enum logic {
    SelEmpty,
    SelHeld
  } sel_state_e;

  typedef enum logic {
    StgEmpty,
    StgFull
  } stg_state_e;

  // A stage may take a new word when empty, or when its word leaves this same cycle
  function automatic logic can_load(input stg_state_e state, input logic ready);
    return (state == StgEmpty) || (PassthruEn && (state == StgFull) && ready);
  endfunction

endpackage

// File: rtl/fifo_demux2_fifo_stage.sv
// One-entry valid/ready output register used for each demux channel.
module fifo_stage
  import fifo_demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_can_load
);

  stg_state_e       r_state;
  logic [WIDTH-1:0] r_data;

  // A load wins over a drain, so drain+load keeps the stage full with the new word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StgEmpty;
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= StgFull;
      r_data  <= i_data;
    end else if ((r_state == StgFull) && i_ready) begin
      r_state <= StgEmpty;
    end
  end

  assign o_data     = r_data;
  assign o_valid    = (r_state == StgFull);
  assign o_can_load = can_load(r_state, i_ready);

endmodule

// File: rtl/fifo_demux2.sv
// Stream demux: each word on a goes to x or y as chosen by one held select decision.
// Optional FIFO_DEMUX2_PASSTHRU_EN allows back-to-back loads into a draining channel.
module fifo_demux2
  import fifo_demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             select,
  input  logic             select_valid,
  output logic             select_ready,
  output logic [WIDTH-1:0] x,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  sel_state_e r_sel_state;
  logic       r_sel_q;

  logic w_x_can_load;
  logic w_y_can_load;
  logic w_a_fire;
  logic w_x_load;
  logic w_y_load;

  assign select_ready = (r_sel_state == SelEmpty);
  assign a_ready      = (r_sel_state == SelHeld) &&
                        ((r_sel_q == SEL_Y) ? w_y_can_load : w_x_can_load);
  assign w_a_fire     = a_valid && a_ready;
  assign w_x_load     = w_a_fire && (r_sel_q == SEL_X);
  assign w_y_load     = w_a_fire && (r_sel_q == SEL_Y);

  // Each select decision is consumed by exactly one word on a
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_state <= SelEmpty;
      r_sel_q     <= SEL_X;
    end else begin
      unique case (r_sel_state)
        SelEmpty: begin
          if (select_valid) begin
            r_sel_q     <= select;
            r_sel_state <= SelHeld;
          end
        end
        SelHeld: begin
          if (w_a_fire) begin
            r_sel_state <= SelEmpty;
          end
        end
        default: r_sel_state <= SelEmpty;
      endcase
    end
  end

  fifo_stage #(
    .WIDTH(WIDTH)
  ) u_stage_x (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_x_load),
    .i_data    (a),
    .i_ready   (x_ready),
    .o_data    (x),
    .o_valid   (x_valid),
    .o_can_load(w_x_can_load)
  );

  fifo_stage #(
    .WIDTH(WIDTH)
  ) u_stage_y (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_y_load),
    .i_data    (a),
    .i_ready   (y_ready),
    .o_data    (y),
    .o_valid   (y_valid),
    .o_can_load(w_y_can_load)
  );

endmodule

// File: tb/tb_fifo_demux2.sv
// Directed self-checking bench for fifo_demux2.
module tb_fifo_demux2;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic         a_valid;
  logic         a_ready;
  logic         select;
  logic         select_valid;
  logic         select_ready;
  logic [W-1:0] x;
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;

  int n_checks = 0;
  int n_errors = 0;

  fifo_demux2 #(
    .WIDTH(W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .select      (select),
    .select_valid(select_valid),
    .select_ready(select_ready),
    .x           (x),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .y           (y),
    .y_valid     (y_valid),
    .y_ready     (y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer select and word together; hold each until its handshake completes
  task automatic send(input logic [W-1:0] word, input logic sel);
    logic sr;
    logic ar;
    a            = word;
    a_valid      = 1'b1;
    select       = sel;
    select_valid = 1'b1;
    for (int i = 0; i < 20 && a_valid; i++) begin
      sr = select_valid && select_ready;
      ar = a_ready;
      step();
      if (sr) select_valid = 1'b0;
      if (ar) a_valid = 1'b0;
    end
    check("send_done", {31'd0, a_valid}, 0);
    a_valid      = 1'b0;
    select_valid = 1'b0;
  endtask

  logic [W-1:0] qx[$];
  logic [W-1:0] qy[$];
  logic [W-1:0] want;
  logic         m_sel;
  logic         st;
  logic         at;
  int           n_xfer;

  initial begin
    // Reset with every valid asserted
    rst = 1'b0; a = 32'd5; a_valid = 1'b1; select = 1'b1; select_valid = 1'b1;
    x_ready = 1'b1; y_ready = 1'b1;
    #1;
    repeat (5) step();
    check("rst_x_valid", {31'd0, x_valid}, 0);
    check("rst_y_valid", {31'd0, y_valid}, 0);
    check("rst_a_ready", {31'd0, a_ready}, 0);
    check("rst_sel_ready", {31'd0, select_ready}, 1);
    check("rst_x_data", x, 0);
    check("rst_y_data", y, 0);
    a_valid = 1'b0; select_valid = 1'b0; x_ready = 1'b0; y_ready = 1'b0;
    rst = 1'b1;
    step();

    // Route to x: word first, select later
    a = 32'd100; a_valid = 1'b1;
    step();
    check("x_stall_no_sel", {31'd0, a_ready}, 0);
    select = 1'b0; select_valid = 1'b1;
    #1;
    check("x_sel_ready", {31'd0, select_ready}, 1);
    step();
    select_valid = 1'b0;
    check("x_sel_held", {31'd0, select_ready}, 0);
    check("x_a_ready", {31'd0, a_ready}, 1);
    step();
    a_valid = 1'b0;
    check("x_valid", {31'd0, x_valid}, 1);
    check("x_data", x, 100);
    check("x_y_quiet", {31'd0, y_valid}, 0);
    check("x_sel_free", {31'd0, select_ready}, 1);
    repeat (3) step();
    check("x_hold_valid", {31'd0, x_valid}, 1);
    check("x_hold_data", x, 100);
    x_ready = 1'b1;
    step();
    x_ready = 1'b0;
    check("x_drained", {31'd0, x_valid}, 0);

    // Route y then x, both held until taken
    send(32'd256, 1'b1);
    check("yx_y_data", y, 256);
    send(32'd100, 1'b0);
    repeat (3) step();
    check("yx_y_valid", {31'd0, y_valid}, 1);
    check("yx_y_hold", y, 256);
    check("yx_x_valid", {31'd0, x_valid}, 1);
    check("yx_x_data", x, 100);
    y_ready = 1'b1;
    step();
    y_ready = 1'b0;
    check("yx_y_drained", {31'd0, y_valid}, 0);
    check("yx_x_still", {31'd0, x_valid}, 1);
    x_ready = 1'b1;
    step();
    x_ready = 1'b0;
    check("yx_x_drained", {31'd0, x_valid}, 0);

    // Back-pressure on x
    send(32'd1, 1'b0);
    a = 32'd2; a_valid = 1'b1; select = 1'b0; select_valid = 1'b1;
    step();
    select_valid = 1'b0;
    repeat (2) step();
    check("bp_a_stall", {31'd0, a_ready}, 0);
    check("bp_x_stable", x, 1);
    check("bp_x_valid", {31'd0, x_valid}, 1);
    x_ready = 1'b1;
    #1;
`ifdef FIFO_DEMUX2_PASSTHRU_EN
    check("bp_pass_ready", {31'd0, a_ready}, 1);
    step();
    x_ready = 1'b0;
    a_valid = 1'b0;
`else
    check("bp_pass_ready", {31'd0, a_ready}, 0);
    step();
    x_ready = 1'b0;
    check("bp_gap_valid", {31'd0, x_valid}, 0);
    check("bp_gap_ready", {31'd0, a_ready}, 1);
    step();
    a_valid = 1'b0;
`endif
    check("bp_x2_valid", {31'd0, x_valid}, 1);
    check("bp_x2_data", x, 2);
    x_ready = 1'b1;
    step();
    x_ready = 1'b0;

    // Throughput with toggling select and both consumers ready
    x_ready = 1'b1; y_ready = 1'b1; select = 1'b0; a = 32'd1000;
    m_sel = 1'b0; n_xfer = 0;
    for (int i = 0; i < 24; i++) begin
      a_valid      = (i < 20);
      select_valid = (i < 20);
      #1;
      st = select_valid && select_ready;
      at = a_valid && a_ready;
      if (x_valid) begin
        if (qx.size() == 0) check("tp_x_extra", 1, 0);
        else begin
          want = qx.pop_front();
          check("tp_x_data", x, want);
        end
      end
      if (y_valid) begin
        if (qy.size() == 0) check("tp_y_extra", 1, 0);
        else begin
          want = qy.pop_front();
          check("tp_y_data", y, want);
        end
      end
      step();
      if (st) begin
        m_sel  = select;
        select = ~select;
      end
      if (at) begin
        if (m_sel) qy.push_back(a);
        else qx.push_back(a);
        a = a + 1;
        n_xfer++;
      end
    end
    check("tp_count", n_xfer, 10);
    check("tp_x_left", qx.size(), 0);
    check("tp_y_left", qy.size(), 0);
    a_valid = 1'b0; select_valid = 1'b0; x_ready = 1'b0; y_ready = 1'b0;
    step();

    // Reset while y is full and a select is held
    send(32'd7, 1'b1);
    select = 1'b0; select_valid = 1'b1;
    step();
    select_valid = 1'b0;
    check("mr_pre_sel", {31'd0, select_ready}, 0);
    check("mr_pre_y", {31'd0, y_valid}, 1);
    rst = 1'b0;
    #1;
    check("mr_y_valid", {31'd0, y_valid}, 0);
    check("mr_sel_ready", {31'd0, select_ready}, 1);
    check("mr_y_data", y, 0);
    step();
    rst = 1'b1;
    a = 32'd9; a_valid = 1'b1; y_ready = 1'b1; x_ready = 1'b1;
    repeat (2) step();
    check("mr_post_a_ready", {31'd0, a_ready}, 0);
    check("mr_post_x", {31'd0, x_valid}, 0);
    check("mr_post_y", {31'd0, y_valid}, 0);
    check("mr_post_sel", {31'd0, select_ready}, 1);
    a_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
